// File: rtl/alu_integer.sv
// alu_integer: registered saturating signed add/sub/mul and bitwise AND with N/Z/C/V flags
module alu_integer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] A,
    input  logic signed [DATA_WIDTH-1:0] B,
    input  logic [1:0]                   opcode,
    output logic signed [DATA_WIDTH-1:0] Out,
    output logic                         C,
    output logic                         N,
    output logic                         V,
    output logic                         Z
);
    localparam int W = DATA_WIDTH;
    localparam int W2 = 2 * DATA_WIDTH;
    localparam logic signed [W2-1:0] LIM_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [W2-1:0] LIM_MIN = ~LIM_MAX;
    localparam logic [W-1:0] OUT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] OUT_MIN = {1'b1, {(W-1){1'b0}}};
    logic signed [W:0]    w_sum;
    logic signed [W:0]    w_dif;
    logic signed [W2-1:0] w_prod;
    logic signed [W2-1:0] w_exact;
    logic [W:0]           w_usum;
    logic                 w_arith;
    logic                 w_hi;
    logic                 w_lo;
    logic [W-1:0]         w_res;
    logic                 w_c;
    logic                 w_v;
    logic [W-1:0]         r_out;
    logic                 r_c;
    logic                 r_n;
    logic                 r_v;
    logic                 r_z;
    // exact results sign-extended to a common 2W width, then clamped to the W-bit range
    always_comb begin
        w_sum   = $signed({A[W-1], A}) + $signed({B[W-1], B});
        w_dif   = $signed({A[W-1], A}) - $signed({B[W-1], B});
        w_prod  = $signed({{W{A[W-1]}}, A}) * $signed({{W{B[W-1]}}, B});
        w_usum  = {1'b0, A} + {1'b0, B};
        w_exact = opcode == 2'b00 ? {{(W-1){w_sum[W]}}, w_sum} :
                  opcode == 2'b01 ? {{(W-1){w_dif[W]}}, w_dif} : w_prod;
        w_arith = opcode != 2'b11;
        w_hi    = w_exact > LIM_MAX;
        w_lo    = w_exact < LIM_MIN;
        w_res   = !w_arith ? A & B : w_hi ? OUT_MAX : w_lo ? OUT_MIN : w_exact[W-1:0];
        w_v     = w_arith & (w_hi | w_lo);
        w_c     = opcode == 2'b00 ? w_usum[W] :
                  opcode == 2'b01 ? $unsigned(A) >= $unsigned(B) : 1'b0;
    end
    // capture result and flags each edge; reset clears everything immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
            r_c   <= 1'b0;
            r_n   <= 1'b0;
            r_v   <= 1'b0;
            r_z   <= 1'b0;
        end else begin
            r_out <= w_res;
            r_c   <= w_c;
            r_n   <= w_res[W-1];
            r_v   <= w_v;
            r_z   <= w_res == '0;
        end
    end
    assign Out = r_out;
    assign C   = r_c;
    assign N   = r_n;
    assign V   = r_v;
    assign Z   = r_z;
endmodule

// File: tb/tb_alu_integer.sv
// tb_alu_integer: directed and random checks of alu_integer against an integer reference model
module tb_alu_integer;
    localparam int W = 8;
    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic signed [W-1:0] A = '0;
    logic signed [W-1:0] B = '0;
    logic [1:0]          opcode = 2'b00;
    logic signed [W-1:0] Out;
    logic                C;
    logic                N;
    logic                V;
    logic                Z;
    int checks = 0;
    int failures = 0;

    alu_integer #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .opcode(opcode),
        .Out(Out), .C(C), .N(N), .V(V), .Z(Z)
    );

    // free-running clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model(input int op, input int a, input int b,
                         output logic [W-1:0] eo, output logic [3:0] ecnvz);
        int ex;
        int ua;
        int ub;
        logic ec;
        logic ev;
        ua = a & 255;
        ub = b & 255;
        case (op)
            0: ex = a + b;
            1: ex = a - b;
            2: ex = a * b;
            default: ex = (ua & ub) > 127 ? (ua & ub) - 256 : (ua & ub);
        endcase
        ev = op != 3 && (ex > 127 || ex < -128);
        if (op != 3 && ex > 127) ex = 127;
        if (op != 3 && ex < -128) ex = -128;
        eo = 8'(ex);
        ec = op == 0 ? (ua + ub > 255) : op == 1 ? (ua >= ub) : 1'b0;
        ecnvz = {ec, eo[W-1], ev, eo == 0};
    endtask

    task automatic apply(input string tag, input int op, input int a, input int b);
        logic [W-1:0] eo;
        logic [3:0] ef;
        @(negedge clk);
        A = 8'(a);
        B = 8'(b);
        opcode = 2'(op);
        model(op, a, b, eo, ef);
        @(posedge clk);
        #1;
        check({tag, ".out"}, {8'h0, Out}, {8'h0, eo});
        check({tag, ".cnvz"}, {12'h0, C, N, V, Z}, {12'h0, ef});
    endtask

    initial begin
        #1;
        check("rst.out", {8'h0, Out}, 16'h0);
        check("rst.cnvz", {12'h0, C, N, V, Z}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply("add1", 0, 1, 1);
        apply("add2", 0, -1, -1);
        apply("add3", 0, 127, 1);
        apply("add4", 0, -2, -128);
        apply("add5", 0, 1, -1);
        apply("add6", 0, 4, -1);
        apply("sub1", 1, 4, 1);
        apply("sub2", 1, -4, -1);
        apply("sub3", 1, 10, -128);
        apply("sub4", 1, -128, 10);
        apply("sub5", 1, -1, -1);
        apply("sub6", 1, 4, 4);
        apply("mul1", 2, 5, 2);
        apply("mul2", 2, -5, 2);
        apply("mul3", 2, -5, -2);
        apply("mul4", 2, 127, 4);
        apply("mul5", 2, -64, 10);
        apply("mul6", 2, 127, 0);
        apply("mul7", 2, -128, -1);
        apply("mul8", 2, -128, 1);
        apply("and1", 3, 'hF0 - 256, 'h3C);
        apply("and2", 3, 'h0F, 'hF0 - 256);
        apply("pre", 0, -1, -1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.out", {8'h0, Out}, 16'h0);
        check("arst.cnvz", {12'h0, C, N, V, Z}, 16'h0);
        @(posedge clk);
        #1;
        check("hold.out", {8'h0, Out}, 16'h0);
        check("hold.cnvz", {12'h0, C, N, V, Z}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply("post", 2, 3, 7);
        for (int i = 0; i < 300; i++) begin
            int op;
            int a;
            int b;
            op = int'($urandom_range(0, 3));
            a = int'($urandom_range(0, 255)) - 128;
            b = int'($urandom_range(0, 255)) - 128;
            if (i % 10 == 0) a = -128;
            if (i % 10 == 1) b = 127;
            if (i % 10 == 2) b = 0;
            apply($sformatf("rnd%0d", i), op, a, b);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_integer.md
Name: alu_integer

Overview:
- Registered signed integer ALU for the execution stage: saturating add, subtract and multiply, plus bitwise AND.
- Two's-complement operands of DATA_WIDTH bits.
- Produces a saturated result and N/Z/C/V condition flags one clock after the operands are presented.

Parameters:
DATA_WIDTH, 8, operand/result width in bits (two's complement, signed); must be >= 2

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
A  input  DATA_WIDTH  signed operand A
B  input  DATA_WIDTH  signed operand B
opcode  input  2  operation select: 00 add, 01 sub, 10 mul, 11 and
Out  output  DATA_WIDTH  signed registered result (saturated for arithmetic ops)
C  output  1  registered carry flag
N  output  1  registered negative flag
V  output  1  registered overflow/saturation flag
Z  output  1  registered zero flag

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: while rst_n=0, Out=0, C=0, N=0, V=0, Z=0, regardless of clk. On release, the first rising edge captures normally.
- Latency: exactly 1 cycle.
  - A, B and opcode are sampled on each rising clk edge.
  - Out and the flags reflect that sample until the next edge.
- Throughput: one operation per cycle; no handshake, no stall.
- Arithmetic: compute the exact signed result in an internal width wide enough to hold it.
  - Add/sub: DATA_WIDTH+1 bits.
  - Mul: 2*DATA_WIDTH bits, signed full product.
- Saturation (ops 00, 01, 10):
  - Exact result > MAX (2^(DATA_WIDTH-1)-1): Out=MAX, V=1.
  - Exact result < MIN (-2^(DATA_WIDTH-1)): Out=MIN, V=1.
  - Otherwise: Out=exact result, V=0.
- opcode 11: Out = A & B bitwise; V=0, C=0.
- N = MSB of the final (saturated) Out.
- Z = 1 iff the final Out == 0. Saturated results are never zero, so V=1 implies Z=0.
- C flag:
  - Add: carry-out of the unsigned DATA_WIDTH-bit sum A+B.
  - Sub: 1 when no unsigned borrow (unsigned A >= unsigned B), else 0.
  - Mul: C=0.
  - C is computed from the raw operands, independent of saturation.
- Boundary cases:
  - MIN*-1, and MIN-B with B>0, saturate with V=1.
  - A-A yields 0 with Z=1, V=0.
  - Multiplying by 0 yields 0 with Z=1, V=0, including A=MAX.
- Asserting reset mid-operation discards any pending captured result; outputs go to 0 immediately.
- Internal datapath is purely combinational between the input sample and the output register. No multi-cycle multiplier.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle with nonzero outputs -> Out=0, C=N=V=Z=0 immediately; after release, operation resumes in 1 cycle.
- Add (opcode 00), DATA_WIDTH=8, one edge per case:
  - 1+1 -> Out=2, N=0, V=0, Z=0.
  - -1+-1 -> Out=-2 (0xFE), N=1, V=0, C=1.
  - 127+1 -> Out=127, V=1, N=0.
  - -2+-128 -> Out=-128, V=1, N=1.
  - 1+-1 -> Out=0, Z=1, C=1.
  - 4+-1 -> Out=3.
- Sub (opcode 01):
  - 4-1 -> Out=3.
  - -4-(-1) -> Out=-3, N=1.
  - 10-(-128) -> Out=127, V=1.
  - -128-10 -> Out=-128, V=1, N=1.
  - -1-(-1) -> Out=0, Z=1.
  - 4-4 -> Out=0, Z=1, C=1.
- Mul (opcode 10):
  - 5*2 -> Out=10.
  - -5*2 -> Out=-10, N=1.
  - -5*-2 -> Out=10, N=0.
  - 127*4 -> Out=127, V=1.
  - -64*10 -> Out=-128, V=1, N=1.
  - 127*0 -> Out=0, Z=1, V=0.
  - C=0 in all mul cases.
- AND (opcode 11):
  - 0xF0 & 0x3C -> Out=0x30, N=0, V=0, C=0.
  - 0x0F & 0xF0 -> Out=0, Z=1.
- Latency/back-to-back: change A, B and opcode every cycle -> each result appears exactly one edge after its inputs, with no holdover of V or C from the prior op.
